// File: rtl/tsc_mc_cpu.sv
// Multi-cycle TSC core: fetch/decode/execute/writeback over a loadable instruction RAM.
// Optional macro TSC_ALU_EXT_EN adds R-type SUB/AND/ORR/NOT/TCP/SHL/SHR.
module tsc_mc_cpu #(
  parameter int          IMEM_AW  = 5,
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic               clk,
  input  logic               reset_cpu,
  input  logic               cpu_enable,
  input  logic               wwd_enable,
  input  logic [1:0]         register_selection,
  input  logic               prog_we,
  input  logic [IMEM_AW-1:0] prog_addr,
  input  logic [15:0]        prog_data,
  output logic [15:0]        num_inst,
  output logic [15:0]        output_port,
  output logic [7:0]         PC_below8bit,
  output logic               halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_BNE = 4'd0;
  localparam logic [3:0] OP_BEQ = 4'd1;
  localparam logic [3:0] OP_BGZ = 4'd2;
  localparam logic [3:0] OP_BLZ = 4'd3;
  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_R   = 4'd15;

  localparam logic [5:0] F_ADD = 6'd0;
  localparam logic [5:0] F_SUB = 6'd1;
  localparam logic [5:0] F_AND = 6'd2;
  localparam logic [5:0] F_ORR = 6'd3;
  localparam logic [5:0] F_NOT = 6'd4;
  localparam logic [5:0] F_TCP = 6'd5;
  localparam logic [5:0] F_SHL = 6'd6;
  localparam logic [5:0] F_SHR = 6'd7;
  localparam logic [5:0] F_WWD = 6'd28;
  localparam logic [5:0] F_HLT = 6'd29;

  state_t      r_state;
  state_t      w_state_nx;

  logic [15:0] r_imem [0:(1<<IMEM_AW)-1];
  logic [15:0] r_regs [0:3];
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_wwd;
  logic [15:0] r_num_inst;
  logic        r_halted;

  // EXEC results held until the WB edge commits them
  logic [15:0] r_res;
  logic        r_we;
  logic [1:0]  r_waddr;
  logic [15:0] r_npc;
  logic        r_wwd_do;
  logic        r_hlt_do;

  logic [3:0]  w_op;
  logic [1:0]  w_rs;
  logic [1:0]  w_rt;
  logic [1:0]  w_rd;
  logic [5:0]  w_func;
  logic [15:0] w_sext;
  logic [15:0] w_pc_inc;
  logic [15:0] w_pc_br;
  logic [15:0] w_res;
  logic        w_we;
  logic [1:0]  w_waddr;
  logic [15:0] w_npc;
  logic        w_wwd;
  logic        w_hlt;

  assign w_op     = r_ir[15:12];
  assign w_rs     = r_ir[11:10];
  assign w_rt     = r_ir[9:8];
  assign w_rd     = r_ir[7:6];
  assign w_func   = r_ir[5:0];
  assign w_sext   = {{8{r_ir[7]}}, r_ir[7:0]};
  assign w_pc_inc = r_pc + 16'd1;
  assign w_pc_br  = r_pc + 16'd1 + w_sext;

  // State register
  always_ff @(posedge clk) begin
    if (reset_cpu) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state logic; HALT is only left through reset
  always_comb begin
    w_state_nx = r_state;
    if (cpu_enable) begin
      case (r_state)
        S_FETCH:  w_state_nx = S_DECODE;
        S_DECODE: w_state_nx = S_EXEC;
        S_EXEC:   w_state_nx = S_WB;
        S_WB:     w_state_nx = r_hlt_do ? S_HALT : S_FETCH;
        S_HALT:   w_state_nx = S_HALT;
        default:  w_state_nx = S_FETCH;
      endcase
    end else begin
      w_state_nx = r_state;
    end
  end

  // Execute: ALU result, write target and next PC
  always_comb begin
    w_res   = 16'h0000;
    w_we    = 1'b0;
    w_waddr = 2'd0;
    w_npc   = w_pc_inc;
    w_wwd   = 1'b0;
    w_hlt   = 1'b0;
    case (w_op)
      OP_BNE: begin
        if (r_a != r_b) w_npc = w_pc_br;
        else            w_npc = w_pc_inc;
      end
      OP_BEQ: begin
        if (r_a == r_b) w_npc = w_pc_br;
        else            w_npc = w_pc_inc;
      end
      OP_BGZ: begin
        if ($signed(r_a) > $signed(16'sd0)) w_npc = w_pc_br;
        else                                w_npc = w_pc_inc;
      end
      OP_BLZ: begin
        if (r_a[15]) w_npc = w_pc_br;
        else         w_npc = w_pc_inc;
      end
      OP_ADI: begin w_res = r_a + w_sext;              w_we = 1'b1; w_waddr = w_rt; end
      OP_ORI: begin w_res = r_a | {8'h00, r_ir[7:0]};  w_we = 1'b1; w_waddr = w_rt; end
      OP_LHI: begin w_res = {r_ir[7:0], 8'h00};        w_we = 1'b1; w_waddr = w_rt; end
      OP_JMP: w_npc = {r_pc[15:12], r_ir[11:0]};
      OP_R: begin
        case (w_func)
          F_ADD: begin w_res = r_a + r_b; w_we = 1'b1; w_waddr = w_rd; end
`ifdef TSC_ALU_EXT_EN
          F_SUB: begin w_res = r_a - r_b;             w_we = 1'b1; w_waddr = w_rd; end
          F_AND: begin w_res = r_a & r_b;             w_we = 1'b1; w_waddr = w_rd; end
          F_ORR: begin w_res = r_a | r_b;             w_we = 1'b1; w_waddr = w_rd; end
          F_NOT: begin w_res = ~r_a;                  w_we = 1'b1; w_waddr = w_rd; end
          F_TCP: begin w_res = 16'd0 - r_a;           w_we = 1'b1; w_waddr = w_rd; end
          F_SHL: begin w_res = {r_a[14:0], 1'b0};     w_we = 1'b1; w_waddr = w_rd; end
          F_SHR: begin w_res = {r_a[15], r_a[15:1]};  w_we = 1'b1; w_waddr = w_rd; end
`else
          F_SUB, F_AND, F_ORR, F_NOT, F_TCP, F_SHL, F_SHR: w_npc = w_pc_inc;
`endif
          F_WWD: begin w_res = r_a; w_wwd = 1'b1; end
          // HLT parks the PC on itself
          F_HLT: begin w_hlt = 1'b1; w_npc = r_pc; end
          default: w_npc = w_pc_inc;
        endcase
      end
      default: w_npc = w_pc_inc;
    endcase
  end

  // Datapath and architectural state
  always_ff @(posedge clk) begin
    if (reset_cpu) begin
      r_pc       <= PC_RESET;
      r_ir       <= 16'h0000;
      r_a        <= 16'h0000;
      r_b        <= 16'h0000;
      r_wwd      <= 16'h0000;
      r_num_inst <= 16'h0000;
      r_halted   <= 1'b0;
      r_res      <= 16'h0000;
      r_we       <= 1'b0;
      r_waddr    <= 2'd0;
      r_npc      <= 16'h0000;
      r_wwd_do   <= 1'b0;
      r_hlt_do   <= 1'b0;
      for (int i = 0; i < 4; i++) r_regs[i] <= 16'h0000;
    end else if (cpu_enable) begin
      case (r_state)
        S_FETCH:  r_ir <= r_imem[r_pc[IMEM_AW-1:0]];
        S_DECODE: begin
          r_a <= r_regs[w_rs];
          r_b <= r_regs[w_rt];
        end
        S_EXEC: begin
          r_res    <= w_res;
          r_we     <= w_we;
          r_waddr  <= w_waddr;
          r_npc    <= w_npc;
          r_wwd_do <= w_wwd;
          r_hlt_do <= w_hlt;
        end
        S_WB: begin
          if (r_we)     r_regs[r_waddr] <= r_res;
          if (r_wwd_do) r_wwd <= r_res;
          if (r_hlt_do) r_halted <= 1'b1;
          r_pc       <= r_npc;
          r_num_inst <= r_num_inst + 16'd1;
        end
        S_HALT:  r_halted <= 1'b1;
        default: r_ir <= r_ir;
      endcase
    end
  end

  // Program load port, only while the core is stopped; contents survive reset
  always_ff @(posedge clk) begin
    if (!reset_cpu && prog_we && !cpu_enable) begin
      r_imem[prog_addr] <= prog_data;
    end
  end

  assign output_port  = wwd_enable ? r_wwd : r_regs[register_selection];
  assign num_inst     = r_num_inst;
  assign PC_below8bit = r_pc[7:0];
  assign halted       = r_halted;

endmodule
